id_ex_pipe_buf: RTL and testbench

Parametrised ID→EX pipeline buffer that generalises the single-entry ID/EX register into a DEPTH-entry elastic buffer with valid/ready handshakes on both sides.
- Decoded payload is opaque: operands, immediate, rd, rd-enable, ALU op/sel, packed to DATA_W bits; PC is carried alongside.
- Sits between decode and execute.
- Absorbs EX back-pressure without a global stall vector.
- Supports a branch-mispredict flush that discards every buffered instruction.

---
 rtl/id_ex_pipe_buf_pkg.sv | 58 +++++
 rtl/id_ex_pipe_buf_if.sv | 50 +++++
 rtl/id_ex_pipe_buf_ctrl.sv | 72 +++++++
 rtl/id_ex_pipe_buf.sv | 98 +++++++++
 tb/tb_id_ex_pipe_buf.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_buf_pkg.sv
// Shared definitions for the ID->EX pipeline buffer: payload field layout
// (so decode packs and EX unpacks identically), default widths and a
// pointer-wrap helper.
package id_ex_pipe_buf_pkg;

    // Field widths of the decoded instruction payload
    localparam int OpCodeLen  = 6;
    localparam int OpSelLen   = 4;
    localparam int RegLen     = 32;
    localparam int RegAddrLen = 5;
    localparam logic Zero     = 1'b0;

    // Field offsets inside the packed payload
    localparam int R1_LSB     = 0;
    localparam int R2_LSB     = R1_LSB + RegLen;
    localparam int IMM_LSB    = R2_LSB + RegLen;
    localparam int RD_LSB     = IMM_LSB + RegLen;
    localparam int RDEN_BIT   = RD_LSB + RegAddrLen;
    localparam int ALUOP_LSB  = RDEN_BIT + 1;
    localparam int ALUSEL_LSB = ALUOP_LSB + OpCodeLen;
    localparam int FIELDS_W   = ALUSEL_LSB + OpSelLen;

    // Payload is rounded up to whole 32-bit words plus one spare word kept
    // free for future decode fields; with the layout above this gives 160.
    localparam int DATA_W_DEF = ((FIELDS_W + 31) / 32 + 1) * 32;
    localparam int PC_W_DEF   = 32;
    localparam int STATS_W    = 32;

    // Pack decoded fields; unused upper bits stay zero so an all-zero word
    // is the NOP/bubble (aluop = 0, rd_enable = 0).
    function automatic logic [DATA_W_DEF-1:0] pack_payload(
        input logic [RegLen-1:0]     r1,
        input logic [RegLen-1:0]     r2,
        input logic [RegLen-1:0]     imm,
        input logic [RegAddrLen-1:0] rd,
        input logic                  rd_en,
        input logic [OpCodeLen-1:0]  aluop,
        input logic [OpSelLen-1:0]   alusel
    );
        logic [DATA_W_DEF-1:0] p;
        p = '0;
        p[R1_LSB +: RegLen]          = r1;
        p[R2_LSB +: RegLen]          = r2;
        p[IMM_LSB +: RegLen]         = imm;
        p[RD_LSB +: RegAddrLen]      = rd;
        p[RDEN_BIT]                  = rd_en;
        p[ALUOP_LSB +: OpCodeLen]    = aluop;
        p[ALUSEL_LSB +: OpSelLen]    = alusel;
        return p;
    endfunction

    // Ring-pointer increment that also handles non-power-of-two depths
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/id_ex_pipe_buf_if.sv
// Handshake bundle between decode, the ID->EX buffer and execute.
// Optional statistics ports appear when ID_EX_PIPE_BUF_STATS_EN is defined.
interface id_ex_pipe_buf_if #(
    parameter int DATA_W = 160,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [PC_W-1:0]   in_pc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [PC_W-1:0]   out_pc_o;
    logic [CNT_W-1:0]  count_o;
`ifdef ID_EX_PIPE_BUF_STATS_EN
    logic [31:0]       stall_cycles_o;
    logic [31:0]       flush_count_o;

    // Pipeline side driving decode/execute/flush
    modport master (
        output flush_i, in_valid_i, in_data_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_pc_o, count_o,
               stall_cycles_o, flush_count_o
    );

    // Buffer side
    modport slave (
        input  flush_i, in_valid_i, in_data_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_pc_o, count_o,
               stall_cycles_o, flush_count_o
    );
`else
    // Pipeline side driving decode/execute/flush
    modport master (
        output flush_i, in_valid_i, in_data_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_pc_o, count_o
    );

    // Buffer side
    modport slave (
        input  flush_i, in_valid_i, in_data_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_pc_o, count_o
    );
`endif
endinterface

// File: rtl/id_ex_pipe_buf_ctrl.sv
// Pointer/occupancy controller for the ID->EX buffer. Owns read/write
// pointers, occupancy count, wrap logic and reset > flush > enq/deq priority.
// Handshake flags come only from registered count, so in_ready never depends
// combinationally on out_ready.
module id_ex_pipe_buf_ctrl
    import id_ex_pipe_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [IDX_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             enq, deq;

    assign in_ready  = (count_reg < FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready & ~flush;

    assign wr_en  = enq;
    assign wr_idx = wr_ptr_reg;
    assign rd_idx = rd_ptr_reg;
    assign count  = count_reg;

    // Next pointer/count values for a non-flush cycle
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (enq) begin
            wr_ptr_next = IDX_W'(wrap_inc(32'(wr_ptr_reg), DEPTH));
        end
        if (deq) begin
            rd_ptr_next = IDX_W'(wrap_inc(32'(rd_ptr_reg), DEPTH));
        end
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // State update: reset wins over flush, flush wins over enq/deq
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/id_ex_pipe_buf.sv
// ID->EX elastic pipeline buffer (DEPTH entries, legal 2..8) with
// valid/ready on both sides and a mispredict flush. Holds the entry storage
// and the bubble-zeroing output mux; pointer control lives in
// id_ex_pipe_buf_ctrl.
// Optional: define ID_EX_PIPE_BUF_STATS_EN for saturating stall/flush
// counters.
module id_ex_pipe_buf
    import id_ex_pipe_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_pipe_buf_if.slave bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + PC_W;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   count;
    logic               in_ready;
    logic               out_valid;
    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [ENTRY_W-1:0] head;

    id_ex_pipe_buf_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush_i),
        .in_valid  (bus.in_valid_i),
        .out_ready (bus.out_ready_i),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .count     (count)
    );

    // Entry storage: contents survive flush/reset, only validity is cleared
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Capture {pc, payload} into this slot when it is the write target
        always_ff @(posedge clk) begin
            if (wr_en && (wr_idx == IDX_W'(gi))) begin
                mem_reg[gi] <= {bus.in_pc_i, bus.in_data_i};
            end
        end
    end

    assign head = mem_reg[rd_idx];

    // Head presentation: empty buffer shows the all-zero NOP bubble
    always_comb begin
        bus.out_data_o = '0;
        bus.out_pc_o   = '0;
        if (out_valid) begin
            bus.out_data_o = head[DATA_W-1:0];
            bus.out_pc_o   = head[ENTRY_W-1:DATA_W];
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = count;

`ifdef ID_EX_PIPE_BUF_STATS_EN
    logic [STATS_W-1:0] stall_cnt_reg;
    logic [STATS_W-1:0] flush_cnt_reg;

    // Saturating counters of decode stall cycles and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (bus.in_valid_i && !in_ready && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + STATS_W'(1);
            end
            if (bus.flush_i && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + STATS_W'(1);
            end
        end
    end

    assign bus.stall_cycles_o = stall_cnt_reg;
    assign bus.flush_count_o  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_pipe_buf.sv
// Self-checking bench for id_ex_pipe_buf. Runs a DEPTH=2 and a DEPTH=3
// instance in lockstep on the same stimulus, each against a queue-based
// reference model, plus directed scenarios on the DEPTH=2 instance.
module tb_id_ex_pipe_buf;
    import id_ex_pipe_buf_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int PW = PC_W_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [PW-1:0] in_pc;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: one queue of {pc, data} per instance
    logic [PW+DW-1:0] mq [2][$];
    int stall_m [2];
    int flush_m [2];
    logic [PW-1:0] pop_log [$];

    always #5 clk = ~clk;

    id_ex_pipe_buf_if #(.DATA_W(DW), .PC_W(PW), .DEPTH(2)) bus2 ();
    id_ex_pipe_buf_if #(.DATA_W(DW), .PC_W(PW), .DEPTH(3)) bus3 ();

    assign bus2.flush_i     = flush;
    assign bus2.in_valid_i  = in_valid;
    assign bus2.in_data_i   = in_data;
    assign bus2.in_pc_i     = in_pc;
    assign bus2.out_ready_i = out_ready;
    assign bus3.flush_i     = flush;
    assign bus3.in_valid_i  = in_valid;
    assign bus3.in_data_i   = in_data;
    assign bus3.in_pc_i     = in_pc;
    assign bus3.out_ready_i = out_ready;

    id_ex_pipe_buf #(.DATA_W(DW), .PC_W(PW), .DEPTH(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    id_ex_pipe_buf #(.DATA_W(DW), .PC_W(PW), .DEPTH(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Behavioural model: FIFO of accepted instructions, bounded by depth
    task automatic model_step(input int k, input int depth);
        bit ready;
        bit enq;
        bit deq;
        if (rst) begin
            mq[k].delete();
            stall_m[k] = 0;
            flush_m[k] = 0;
        end else begin
            ready = (mq[k].size() < depth);
            if (in_valid && !ready) stall_m[k]++;
            if (flush) begin
                flush_m[k]++;
                mq[k].delete();
            end else begin
                deq = (mq[k].size() != 0) && out_ready;
                enq = in_valid && ready;
                if (deq) void'(mq[k].pop_front());
                if (enq) mq[k].push_back({in_pc, in_data});
            end
        end
    endtask

    task automatic check_inst(input string nm, input int k, input int depth,
                              input logic v, input logic r, input int c,
                              input logic [DW-1:0] d, input logic [PW-1:0] p);
        int sz;
        logic [DW-1:0] ed;
        logic [PW-1:0] ep;
        sz = mq[k].size();
        ed = '0;
        ep = '0;
        if (sz != 0) begin
            ed = mq[k][0][DW-1:0];
            ep = mq[k][0][PW+DW-1:DW];
        end
        check({nm, ".valid"}, 256'(v), 256'(sz != 0));
        check({nm, ".ready"}, 256'(r), 256'(sz < depth));
        check({nm, ".count"}, 256'(c), 256'(sz));
        check({nm, ".data"},  256'(d), 256'(ed));
        check({nm, ".pc"},    256'(p), 256'(ep));
    endtask

    // One clock: log dut2 dequeue, advance model at the edge, check at negedge
    task automatic cycle();
        if (!rst && !flush && bus2.out_valid_o && out_ready) begin
            pop_log.push_back(bus2.out_pc_o);
            $display("cyc %0d d2 pop pc=%08h cnt=%0d", cyc, bus2.out_pc_o, bus2.count_o);
        end
        @(posedge clk);
        model_step(0, 2);
        model_step(1, 3);
        @(negedge clk);
        cyc++;
        check_inst("d2", 0, 2, bus2.out_valid_o, bus2.in_ready_o, int'(bus2.count_o),
                   bus2.out_data_o, bus2.out_pc_o);
        check_inst("d3", 1, 3, bus3.out_valid_o, bus3.in_ready_o, int'(bus3.count_o),
                   bus3.out_data_o, bus3.out_pc_o);
`ifdef ID_EX_PIPE_BUF_STATS_EN
        check("d2.stall", 256'(bus2.stall_cycles_o), 256'(stall_m[0]));
        check("d2.flushcnt", 256'(bus2.flush_count_o), 256'(flush_m[0]));
        check("d3.stall", 256'(bus3.stall_cycles_o), 256'(stall_m[1]));
        check("d3.flushcnt", 256'(bus3.flush_count_o), 256'(flush_m[1]));
`endif
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0;

        // Reset for two cycles, then a single push/pop
        cycle(); cycle();
        check("rst.count", 256'(bus2.count_o), 256'(0));
        check("rst.ready", 256'(bus2.in_ready_o), 256'(1));
        idle();
        in_valid = 1'b1; in_data = DW'(8'hA5); in_pc = 32'h100; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("push.valid", 256'(bus2.out_valid_o), 256'(1));
        check("push.data", 256'(bus2.out_data_o), 256'(8'hA5));
        check("push.pc", 256'(bus2.out_pc_o), 256'(32'h100));
        cycle();
        check("push.count0", 256'(bus2.count_o), 256'(0));
        cycle(); cycle();

        // Back-pressure fill and ordered drain
        pop_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = rand_data(); in_pc = 32'(4 * i);
            cycle();
        end
        in_valid = 1'b1; in_data = rand_data(); in_pc = 32'h8;
        cycle();
        check("fill.count", 256'(bus2.count_o), 256'(2));
        check("fill.ready", 256'(bus2.in_ready_o), 256'(0));
        out_ready = 1'b1;
        guard = 0;
        while (!bus2.in_ready_o && guard < 20) begin
            cycle();
            guard++;
        end
        if (guard >= 20) check("fill.timeout", 256'(guard), 256'(0));
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("drain.n", 256'(pop_log.size()), 256'(3));
        for (int i = 0; i < 3 && i < pop_log.size(); i++)
            check("drain.pc", 256'(pop_log[i]), 256'(4 * i));

        // Steady streaming: one in, one out per cycle
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_data = rand_data(); in_pc = 32'h200 + 32'(4 * i);
            cycle();
            check("stream.count", 256'(bus2.count_o), 256'(1));
            check("stream.pc", 256'(bus2.out_pc_o), 256'(32'h200 + 4 * i));
        end
        in_valid = 1'b0;
        cycle(); cycle();

        // Flush with full buffer and an incoming instruction
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = rand_data(); in_pc = 32'h300 + 32'(4 * i);
            cycle();
        end
        check("flush.pre", 256'(bus2.count_o), 256'(2));
        flush = 1'b1; in_valid = 1'b1; in_data = rand_data(); in_pc = 32'h20;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush.valid", 256'(bus2.out_valid_o), 256'(0));
        check("flush.data", 256'(bus2.out_data_o), 256'(0));
        check("flush.pc", 256'(bus2.out_pc_o), 256'(0));
        check("flush.count", 256'(bus2.count_o), 256'(0));
        cycle(); cycle();
        check("flush.gone", 256'(bus2.out_valid_o), 256'(0));

        // Flush together with reset
        in_valid = 1'b1; in_pc = 32'h40; cycle();
        rst = 1'b1; flush = 1'b1; cycle();
        idle();
        check("rstflush.count", 256'(bus2.count_o), 256'(0));

`ifdef ID_EX_PIPE_BUF_STATS_EN
        // Stats: two accepted then five stalled cycles, then two flushes
        rst = 1'b1; cycle(); idle();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = rand_data(); in_pc = 32'h500 + 32'(4 * i);
            cycle();
        end
        check("stats.stall5", 256'(bus2.stall_cycles_o), 256'(5));
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush = 1'b1; cycle();
            flush = 1'b0; cycle();
        end
        check("stats.flush2", 256'(bus2.flush_count_o), 256'(2));
`endif

        // Randomised traffic; DEPTH=3 instance exercises non-power-of-2 wrap
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rand_data();
            in_pc     = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
